// File: rtl/reg_bridge_burst.sv
// reg_bridge_burst: framed byte-stream command parser driving a register bus.
//
// Frame: MAGIC, TYPE, AB address bytes (LSB first), then for writes DB data
// bytes per word (LSB first). TYPE[0] = write, TYPE[7:4] = burst length - 1.
// Every word, written or not, is read back and returned as DB reply bytes
// (LSB first). Bursts auto-increment the address, wrapping modulo 2^ADDR_W.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_wr, cmd_in          host command byte stream
//   reply_out/rdy/ack/end   reply byte stream back to the host
//   reg_addr, reg_wdata     register bus address / write data
//   reg_wr, reg_rd          one-cycle write / read strobes
//   reg_rdata               read data, valid RD_LAT cycles after reg_rd
//   err_count               saturating protocol error count
module reg_bridge_burst #(
    parameter int         ADDR_W  = 16,
    parameter int         DATA_W  = 32,
    parameter logic [7:0] MAGIC   = 8'hAA,
    parameter int         RD_LAT  = 1,
    parameter int         TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_wr,
    input  logic [7:0]        cmd_in,
    output logic [7:0]        reply_out,
    output logic              reply_rdy,
    input  logic              reply_ack,
    output logic              reply_end,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [7:0]        err_count
);
    localparam int AB = (ADDR_W + 7) / 8;
    localparam int DB = DATA_W / 8;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_TYPE, S_ADDR, S_DATA, S_WSTB, S_RSTB, S_RWAIT, S_REPLY
    } state_t;

    state_t              state, state_nx;
    logic                is_wr;
    logic [3:0]          words_left;
    logic [2:0]          byte_cnt;
    logic [AB*8-1:0]     addr_sh, addr_nx;
    logic [DATA_W-1:0]   wdata_nx;
    logic [DATA_W-1:0]   rep_sh;
    logic [TW-1:0]       to_cnt;
    logic                in_frame, tmo, stray;
    logic                last_addr, last_data, last_rep;
    // vld_pipe[k] is high k cycles after the reg_rd strobe
    logic [RD_LAT:0]     vld_pipe;
    logic [RD_LAT-1:0]   vld_q;

    assign vld_pipe  = {vld_q, reg_rd};

    // Bytes arrive LSB first, so shift each new byte in from the top.
    assign addr_nx   = (addr_sh >> 8) | ((AB*8)'(cmd_in) << (8 * (AB - 1)));
    assign wdata_nx  = (reg_wdata >> 8) | (DATA_W'(cmd_in) << (DATA_W - 8));

    assign in_frame  = (state == S_TYPE) || (state == S_ADDR) || (state == S_DATA);
    // cmd_wr on the expiry cycle wins over the timeout
    assign tmo       = in_frame && !cmd_wr && (to_cnt == TW'(TIMEOUT - 1));
    assign stray     = cmd_wr && !in_frame && (state != S_IDLE);
    assign last_addr = byte_cnt == 3'(AB - 1);
    assign last_data = byte_cnt == 3'(DB - 1);
    assign last_rep  = reply_ack && last_data;

    assign reg_wr    = state == S_WSTB;
    assign reg_rd    = state == S_RSTB;
    assign reply_rdy = state == S_REPLY;
    assign reply_out = rep_sh[7:0];
    assign reply_end = reply_rdy && last_data && (words_left == 4'd0);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cmd_wr && cmd_in == MAGIC) state_nx = S_TYPE;
            S_TYPE:  if (cmd_wr) state_nx = S_ADDR;
            S_ADDR:  if (cmd_wr && last_addr) state_nx = is_wr ? S_DATA : S_RSTB;
            S_DATA:  if (cmd_wr && last_data) state_nx = S_WSTB;
            S_WSTB:  state_nx = S_RSTB;
            S_RSTB:  state_nx = S_RWAIT;
            S_RWAIT: if (vld_pipe[RD_LAT]) state_nx = S_REPLY;
            S_REPLY: if (last_rep) begin
                if (words_left != 4'd0) state_nx = is_wr ? S_DATA : S_RSTB;
                else                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (tmo) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            is_wr      <= 1'b0;
            words_left <= '0;
            byte_cnt   <= '0;
            addr_sh    <= '0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            rep_sh     <= '0;
            to_cnt     <= '0;
            err_count  <= '0;
            vld_q      <= '0;
        end else begin
            state <= state_nx;
            vld_q <= vld_pipe[RD_LAT-1:0];
            // idle-cycle counter only runs while a frame is being received
            to_cnt <= (cmd_wr || !in_frame) ? '0 : to_cnt + 1'b1;
            if ((tmo || stray) && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            case (state)
                S_TYPE: if (cmd_wr) begin
                    is_wr      <= cmd_in[0];
                    words_left <= cmd_in[7:4];
                    byte_cnt   <= '0;
                end
                S_ADDR: if (cmd_wr) begin
                    addr_sh  <= addr_nx;
                    byte_cnt <= last_addr ? 3'd0 : byte_cnt + 3'd1;
                    if (last_addr) reg_addr <= addr_nx[ADDR_W-1:0];
                end
                S_DATA: if (cmd_wr) begin
                    reg_wdata <= wdata_nx;
                    byte_cnt  <= last_data ? 3'd0 : byte_cnt + 3'd1;
                end
                S_RWAIT: if (vld_pipe[RD_LAT]) rep_sh <= reg_rdata;
                S_REPLY: if (reply_ack) begin
                    rep_sh <= rep_sh >> 8;
                    if (last_data) begin
                        byte_cnt <= '0;
                        if (words_left != 4'd0) begin
                            words_left <= words_left - 4'd1;
                            reg_addr   <= reg_addr + 1'b1;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
